// File: rtl/program_encoder_pkg.sv
// Request payload carried on the program encoder's request bus.
package program_encoder_pkg;
  import riscv_pkg::*;

  typedef struct packed {
    logic [ENC_OP_W-1:0] op;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [IMM_W-1:0]    imm;
    logic                last;
  } req_t;

endpackage

// File: rtl/riscv_pkg.sv
// RV32I encoding constants, the request opcode enum and field-packing helpers
// shared by the program encoder and anything that builds instruction words.
package riscv_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned ENC_OP_W = 5;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 13;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [ENC_OP_W-1:0] {
    ENC_ADD  = 5'd0,  ENC_SUB  = 5'd1,  ENC_AND  = 5'd2,  ENC_OR   = 5'd3,
    ENC_XOR  = 5'd4,  ENC_SLL  = 5'd5,  ENC_SRL  = 5'd6,  ENC_SRA  = 5'd7,
    ENC_SLT  = 5'd8,  ENC_ADDI = 5'd9,  ENC_ANDI = 5'd10, ENC_ORI  = 5'd11,
    ENC_XORI = 5'd12, ENC_SLTI = 5'd13, ENC_LW   = 5'd14, ENC_SW   = 5'd15,
    ENC_BEQ  = 5'd16, ENC_BNE  = 5'd17
  } enc_op_t;

  function automatic logic [INSTR_W-1:0] enc_r(input logic [6:0] f7,
                                               input logic [REG_W-1:0] rs2,
                                               input logic [REG_W-1:0] rs1,
                                               input logic [2:0] f3,
                                               input logic [REG_W-1:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [INSTR_W-1:0] enc_i(input logic [11:0] imm,
                                               input logic [REG_W-1:0] rs1,
                                               input logic [2:0] f3,
                                               input logic [REG_W-1:0] rd,
                                               input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [INSTR_W-1:0] enc_s(input logic [11:0] imm,
                                               input logic [REG_W-1:0] rs2,
                                               input logic [REG_W-1:0] rs1);
    return {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
  endfunction

  // imm here is the byte offset with bit 0 already dropped (offset[12:1]).
  function automatic logic [INSTR_W-1:0] enc_b(input logic [12:1] imm,
                                               input logic [REG_W-1:0] rs2,
                                               input logic [REG_W-1:0] rs1,
                                               input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

endpackage

// File: rtl/program_encoder_if.sv
// Request handshake plus instruction-memory write port of the program encoder.
interface program_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  import program_encoder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  req_t              req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req,
    output req_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/program_encoder_encode.sv
// Combinational RV32I encoder for the supported request ops.
// IMM_CHECK_EN: reject out-of-range I/S immediates and odd branch offsets.
module instr_encode
  import riscv_pkg::*;
(
  input  logic [ENC_OP_W-1:0] op_i,
  input  logic [REG_W-1:0]    rd_i,
  input  logic [REG_W-1:0]    rs1_i,
  input  logic [REG_W-1:0]    rs2_i,
  input  logic [IMM_W-1:0]    imm_i,
  output logic [INSTR_W-1:0]  word_c_o,
  output logic                illegal_c_o
);

  logic imm12_bad_c;
  logic immb_bad_c;

`ifdef IMM_CHECK_EN
  assign imm12_bad_c = imm_i[12] ^ imm_i[11];
  assign immb_bad_c  = imm_i[0];
`else
  assign imm12_bad_c = 1'b0;
  assign immb_bad_c  = 1'b0;
`endif

  always_comb begin
    word_c_o    = '0;
    illegal_c_o = 1'b0;
    case (op_i)
      ENC_ADD:  word_c_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i);
      ENC_SUB:  word_c_o = enc_r(F7_ALT,  rs2_i, rs1_i, F3_ADD_SUB, rd_i);
      ENC_AND:  word_c_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_AND,     rd_i);
      ENC_OR:   word_c_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_OR,      rd_i);
      ENC_XOR:  word_c_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_XOR,     rd_i);
      ENC_SLL:  word_c_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLL,     rd_i);
      ENC_SRL:  word_c_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SRL_SRA, rd_i);
      ENC_SRA:  word_c_o = enc_r(F7_ALT,  rs2_i, rs1_i, F3_SRL_SRA, rd_i);
      ENC_SLT:  word_c_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLT,     rd_i);
      ENC_ADDI: begin
        word_c_o    = enc_i(imm_i[11:0], rs1_i, F3_ADD_SUB, rd_i, OP_I);
        illegal_c_o = imm12_bad_c;
      end
      ENC_ANDI: begin
        word_c_o    = enc_i(imm_i[11:0], rs1_i, F3_AND, rd_i, OP_I);
        illegal_c_o = imm12_bad_c;
      end
      ENC_ORI: begin
        word_c_o    = enc_i(imm_i[11:0], rs1_i, F3_OR, rd_i, OP_I);
        illegal_c_o = imm12_bad_c;
      end
      ENC_XORI: begin
        word_c_o    = enc_i(imm_i[11:0], rs1_i, F3_XOR, rd_i, OP_I);
        illegal_c_o = imm12_bad_c;
      end
      ENC_SLTI: begin
        word_c_o    = enc_i(imm_i[11:0], rs1_i, F3_SLT, rd_i, OP_I);
        illegal_c_o = imm12_bad_c;
      end
      ENC_LW: begin
        word_c_o    = enc_i(imm_i[11:0], rs1_i, F3_LW, rd_i, OP_LOAD);
        illegal_c_o = imm12_bad_c;
      end
      ENC_SW: begin
        word_c_o    = enc_s(imm_i[11:0], rs2_i, rs1_i);
        illegal_c_o = imm12_bad_c;
      end
      ENC_BEQ: begin
        word_c_o    = enc_b(imm_i[12:1], rs2_i, rs1_i, F3_BEQ);
        illegal_c_o = immb_bad_c;
      end
      ENC_BNE: begin
        word_c_o    = enc_b(imm_i[12:1], rs2_i, rs1_i, F3_BNE);
        illegal_c_o = immb_bad_c;
      end
      default:  illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_encoder.sv
// Accepts symbolic instruction requests, encodes them and writes them to
// consecutive instruction-memory words starting at 0 after each start pulse.
module program_encoder
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH  = 256,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  program_encoder_if.slave    bus,
  output logic                busy_c_o,
  output logic                done_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    count_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q,   ptr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               we_q,    we_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               done_q,  done_d;
  logic               err_q,   err_d;

  logic [INSTR_W-1:0] enc_word_c;
  logic               enc_illegal_c;
  logic               accept_c;

  instr_encode u_encode (
    .op_i        (bus.req.op),
    .rd_i        (bus.req.rd),
    .rs1_i       (bus.req.rs1),
    .rs2_i       (bus.req.rs2),
    .imm_i       (bus.req.imm),
    .word_c_o    (enc_word_c),
    .illegal_c_o (enc_illegal_c)
  );

  // start pre-empts any accept in the same cycle
  assign accept_c      = (state_q == ST_LOAD) && bus.req_valid && !start_i;
  assign bus.req_ready = (state_q == ST_LOAD) && !start_i;
  assign busy_c_o      = (state_q == ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    if (start_i) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (accept_c) begin
      if (enc_illegal_c) begin
        state_d = ST_ERR;
        err_d   = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc_word_c;
        ptr_d   = ptr_q + ADDR_W'(1);
        cnt_d   = cnt_q + CNT_W'(1);
        // last wins over overflow: a program that exactly fills memory is fine
        if (bus.req.last) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign count_o        = cnt_q;

endmodule

// File: tb/tb_program_encoder.sv
// Directed bench for program_encoder with a 4-word memory; expected words are
// hand-assembled RV32I encodings.
module tb_program_encoder;
  import riscv_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;
  logic [ADDR_W:0] count;

  program_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  program_encoder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .bus      (bus),
    .busy_c_o (busy),
    .done_o   (done),
    .err_o    (err),
    .count_o  (count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int nw      = 0;
  int base    = 0;
  logic [ADDR_W-1:0] log_addr [64];
  logic [31:0]       log_data [64];

  // write-port monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1 && nw < 64) begin
      log_addr[nw] = bus.imem_addr;
      log_data[nw] = bus.imem_wdata;
      nw++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [ADDR_W-1:0] a, input logic [31:0] d);
    check({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
    check({tag, "_data"}, log_data[idx], d);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // drive one request; returns just after the cycle in which it was accepted
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm, input logic last);
    int n;
    n = 0;
    bus.req.op   = op;
    bus.req.rd   = rd;
    bus.req.rs1  = rs1;
    bus.req.rs2  = rs2;
    bus.req.imm  = imm;
    bus.req.last = last;
    bus.req_valid = 1'b1;
    #1;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("send_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req       = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_we",    32'(bus.imem_we),   32'd0);
    check("rst_addr",  32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata,     32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores requests
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_ready", 32'(bus.req_ready), 32'd0);
    check("idle_nowr",  32'(nw), 32'd0);
    bus.req_valid = 1'b0;

    // R-type pair
    pulse_start();
    check("a_busy", 32'(busy), 32'd1);
    base = nw;
    send(ENC_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    send(ENC_SUB, 5'd5, 5'd6, 5'd7, 13'd0, 1'b1);
    check("a_done",  32'(done), 32'd1);
    check("a_we",    32'(bus.imem_we), 32'd1);
    check("a_count", 32'(count), 32'd2);
    check("a_nw",    32'(nw - base), 32'd2);
    check_write("a_w0", base,     2'd0, 32'h002081B3);
    check_write("a_w1", base + 1, 2'd1, 32'h407302B3);
    bus.req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("a_hold_ready", 32'(bus.req_ready), 32'd0);
    check("a_hold_nw",    32'(nw - base), 32'd2);
    check("a_hold_done",  32'(done), 32'd1);
    bus.req_valid = 1'b0;

    // I, S and B formats
    pulse_start();
    check("b_done_clr", 32'(done), 32'd0);
    base = nw;
    send(ENC_ADDI, 5'd1, 5'd0, 5'd0, 13'h1FFF, 1'b0);
    send(ENC_SW,   5'd0, 5'd1, 5'd2, 13'd8,    1'b0);
    send(ENC_BEQ,  5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1);
    check("b_count", 32'(count), 32'd3);
    check("b_nw",    32'(nw - base), 32'd3);
    check_write("b_w0", base,     2'd0, 32'hFFF00093);
    check_write("b_w1", base + 1, 2'd1, 32'h0020A423);
    check_write("b_w2", base + 2, 2'd2, 32'hFE208EE3);

    // illegal op
    pulse_start();
    base = nw;
    send(5'd20, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
    check("c_err",   32'(err), 32'd1);
    check("c_we",    32'(bus.imem_we), 32'd0);
    check("c_ready", 32'(bus.req_ready), 32'd0);
    check("c_count", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("c_nw",   32'(nw - base), 32'd0);
    check("c_done", 32'(done), 32'd0);
    check("c_err_hold", 32'(err), 32'd1);

    // overflow at DEPTH words without last
    pulse_start();
    check("d_err_clr", 32'(err), 32'd0);
    base = nw;
    send(ENC_LW,   5'd4, 5'd2, 5'd0, 13'd16,   1'b0);
    send(ENC_BNE,  5'd0, 5'd3, 5'd4, 13'd8,    1'b0);
    send(ENC_SRA,  5'd1, 5'd2, 5'd3, 13'd0,    1'b0);
    send(ENC_XORI, 5'd2, 5'd2, 5'd0, 13'd2047, 1'b0);
    check("d_err",   32'(err), 32'd1);
    check("d_done",  32'(done), 32'd0);
    check("d_count", 32'(count), 32'd4);
    check("d_nw",    32'(nw - base), 32'd4);
    check_write("d_w0", base,     2'd0, 32'h01012203);
    check_write("d_w1", base + 1, 2'd1, 32'h00419463);
    check_write("d_w2", base + 2, 2'd2, 32'h403150B3);
    check_write("d_w3", base + 3, 2'd3, 32'h7FF14113);
    #5;
    check("d_ready", 32'(bus.req_ready), 32'd0);

    // restart mid-load with a request pending in the start cycle
    pulse_start();
    base = nw;
    send(ENC_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    bus.req.op = ENC_OR; bus.req.rd = 5'd7; bus.req.rs1 = 5'd8;
    bus.req.rs2 = 5'd9;  bus.req.imm = 13'd0; bus.req.last = 1'b1;
    bus.req_valid = 1'b1;
    start = 1'b1;
    #1;
    check("e_ready_start", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("e_count0", 32'(count), 32'd0);
    check("e_we0",    32'(bus.imem_we), 32'd0);
    check("e_busy",   32'(busy), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("e_count1", 32'(count), 32'd1);
    check("e_done",   32'(done), 32'd1);
    check("e_nw",     32'(nw - base), 32'd2);
    check_write("e_w0", base,     2'd0, 32'h002081B3);
    check_write("e_w1", base + 1, 2'd0, 32'h009463B3);

    // reset while a write strobe is on the bus
    pulse_start();
    base = nw;
    send(ENC_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("f_we",    32'(bus.imem_we), 32'd0);
    check("f_busy",  32'(busy), 32'd0);
    check("f_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("f_nw",    32'(nw - base), 32'd1);
    check("f_ready", 32'(bus.req_ready), 32'd0);

    // immediate out of signed 12-bit range
    pulse_start();
    base = nw;
    send(ENC_ADDI, 5'd0, 5'd0, 5'd0, 13'd2048, 1'b1);
`ifdef IMM_CHECK_EN
    check("g_err",  32'(err), 32'd1);
    check("g_we",   32'(bus.imem_we), 32'd0);
    check("g_nw",   32'(nw - base), 32'd0);
`else
    check("g_done", 32'(done), 32'd1);
    check("g_err",  32'(err), 32'd0);
    check("g_nw",   32'(nw - base), 32'd1);
    check_write("g_w0", base, 2'd0, 32'h80000013);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
